// File: rtl/mul_clamp_controller_pkg.sv
// Shared types and defaults for the multiply-and-clamp controller.
// Holds the FSM state encoding and the iteration-limit default.
package mul_clamp_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH,
    SAT,
    ERR,
    DONE
  } state_t;

  localparam int N_DEF = 8;

  function automatic int max_iter_def(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/mul_clamp_controller_iter_counter.sv
// Iteration counter for the multiply-and-clamp controller.
// Clears on LOAD, increments per RUN cycle, flags the iteration limit.
module iter_counter #(
  parameter int n        = 8,
  parameter int MAX_ITER = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [n-1:0] count,
  output logic         tc
);

  localparam logic [n-1:0] LIMIT = n'(MAX_ITER);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LIMIT);

endmodule

// File: rtl/mul_clamp_controller.sv
// Control FSM for a multiply-and-clamp datapath.
// Sequences load, iterate, clamp/finish/abort and reports status.
module mul_clamp_controller
  import mul_clamp_controller_pkg::*;
#(
  parameter int n        = N_DEF,
  parameter int MAX_ITER = max_iter_def(n)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         cmp_res,
  input  logic         nor_res,
  output logic         reset_regs,
  output logic         sel_r1,
  output logic         sel_r5,
  output logic         en,
  output logic         busy,
  output logic         done,
  output logic         sat,
  output logic         err,
  output logic [n-1:0] iter_cnt
);

  state_t state;
  state_t nxt;
  logic   clr;
  logic   inc;
  logic   tc;

  iter_counter #(
    .n        (n),
    .MAX_ITER (MAX_ITER)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .count (iter_cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Status flags are captured in the one-cycle outcome states
  // and stay put until the next operation is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        LOAD, FINISH: begin
          sat <= 1'b0;
          err <= 1'b0;
        end
        SAT: begin
          sat <= 1'b1;
          err <= 1'b0;
        end
        ERR: begin
          sat <= 1'b0;
          err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt        = state;
    reset_regs = 1'b1;
    sel_r1     = 1'b0;
    sel_r5     = 1'b1;
    en         = 1'b0;
    done       = 1'b0;
    clr        = 1'b0;
    inc        = 1'b0;
    case (state)
      IDLE: begin
        if (start) nxt = LOAD;
      end
      LOAD: begin
        reset_regs = 1'b0;
        clr        = 1'b1;
        nxt        = RUN;
      end
      RUN: begin
        sel_r1 = 1'b1;
        if (cmp_res) begin
          nxt = SAT;
        end else if (nor_res) begin
          nxt = FINISH;
        end else if (tc) begin
          nxt = ERR;
        end else begin
          en  = 1'b1;
          inc = 1'b1;
        end
      end
      FINISH: nxt = DONE;
      SAT: begin
        sel_r5 = 1'b0;
        nxt    = DONE;
      end
      ERR: begin
        sel_r5 = 1'b0;
        nxt    = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_clamp_controller.sv
// Testbench for mul_clamp_controller: scoreboard of expected
// completions checked against each done pulse.
module tb_mul_clamp_controller;

  typedef struct {
    bit sat;
    bit err;
    int iter;
    int t0;
    int lat;
  } exp_t;

  logic       clk = 0;
  logic       reset = 1;
  logic       start = 0;
  logic       cmp_res = 0;
  logic       nor_res = 0;
  logic       reset_regs, sel_r1, sel_r5, en, busy, done, sat, err;
  logic [7:0] iter_cnt;

  logic       start4 = 0;
  logic       zero4 = 0;
  logic       reset_regs4, sel_r14, sel_r54, en4, busy4, done4, sat4, err4;
  logic [3:0] iter_cnt4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t q4[$];
  exp_t me;
  exp_t me4;

  mul_clamp_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmp_res    (cmp_res),
    .nor_res    (nor_res),
    .reset_regs (reset_regs),
    .sel_r1     (sel_r1),
    .sel_r5     (sel_r5),
    .en         (en),
    .busy       (busy),
    .done       (done),
    .sat        (sat),
    .err        (err),
    .iter_cnt   (iter_cnt)
  );

  mul_clamp_controller #(
    .n        (4),
    .MAX_ITER (15)
  ) dut4 (
    .clk        (clk),
    .reset      (reset),
    .start      (start4),
    .cmp_res    (zero4),
    .nor_res    (zero4),
    .reset_regs (reset_regs4),
    .sel_r1     (sel_r14),
    .sel_r5     (sel_r54),
    .en         (en4),
    .busy       (busy4),
    .done       (done4),
    .sat        (sat4),
    .err        (err4),
    .iter_cnt   (iter_cnt4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected at cycle %0d: done=1 with nothing pending", cyc);
      end else begin
        me = q.pop_front();
        if (sat !== me.sat || err !== me.err) begin
          errors++;
          $display("FAIL done_flags: sat=%b err=%b, expected sat=%b err=%b",
                   sat, err, me.sat, me.err);
        end
        checks++;
        if (int'(iter_cnt) !== me.iter) begin
          errors++;
          $display("FAIL done_iter: iter_cnt=%0d, expected %0d", iter_cnt, me.iter);
        end
        checks++;
        if (cyc - me.t0 !== me.lat) begin
          errors++;
          $display("FAIL done_latency: %0d cycles, expected %0d", cyc - me.t0, me.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL done4_unexpected at cycle %0d", cyc);
      end else begin
        me4 = q4.pop_front();
        if (sat4 !== me4.sat || err4 !== me4.err) begin
          errors++;
          $display("FAIL done4_flags: sat=%b err=%b, expected sat=%b err=%b",
                   sat4, err4, me4.sat, me4.err);
        end
        checks++;
        if (int'(iter_cnt4) !== me4.iter) begin
          errors++;
          $display("FAIL done4_iter: iter_cnt=%0d, expected %0d", iter_cnt4, me4.iter);
        end
        checks++;
        if (cyc - me4.t0 !== me4.lat) begin
          errors++;
          $display("FAIL done4_latency: %0d cycles, expected %0d", cyc - me4.t0, me4.lat);
        end
      end
    end
  end

  task automatic check_reset_vals(input string nm);
    checks++;
    if ({reset_regs, sel_r1, sel_r5, en, busy, done, sat, err} !== 8'b1010_0000
        || iter_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s: outs=%b iter=%0d, expected outs=10100000 iter=0", nm,
               {reset_regs, sel_r1, sel_r5, en, busy, done, sat, err}, iter_cnt);
    end
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d completions pending, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic op(input int nrun, input bit cmp, input bit nor_also,
                    input bit repulse, input bit exp_sat, input int exp_iter,
                    input string nm);
    exp_t e;
    logic exp_en;
    @(posedge clk); #1;
    start = 1;
    e.sat = exp_sat; e.err = 0; e.iter = exp_iter; e.t0 = cyc; e.lat = 3 + nrun;
    q.push_back(e);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checks++;
    if (reset_regs !== 1'b0 || busy !== 1'b1 || en !== 1'b0 || sel_r1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_load: rr=%b busy=%b en=%b s1=%b, expected 0 1 0 0",
               nm, reset_regs, busy, en, sel_r1);
    end
    for (int j = 1; j <= nrun; j++) begin
      @(posedge clk); #1;
      start = repulse && (j == 1);
      if (j == nrun) begin
        cmp_res = cmp;
        nor_res = !cmp || nor_also;
      end
      exp_en = (j != nrun);
      @(negedge clk);
      checks++;
      if (en !== exp_en || sel_r1 !== 1'b1 || busy !== 1'b1 || reset_regs !== 1'b1) begin
        errors++;
        $display("FAIL %s_run%0d: en=%b s1=%b busy=%b rr=%b, expected en=%b 1 1 1",
                 nm, j, en, sel_r1, busy, reset_regs, exp_en);
      end
      checks++;
      if (int'(iter_cnt) !== j - 1) begin
        errors++;
        $display("FAIL %s_iter%0d: iter_cnt=%0d, expected %0d", nm, j, iter_cnt, j - 1);
      end
    end
    @(posedge clk); #1;
    start = 0;
    cmp_res = 0;
    nor_res = 0;
    @(negedge clk);
    checks++;
    if (sel_r5 !== !cmp || en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_exit: s5=%b en=%b busy=%b, expected s5=%b en=0 busy=1",
               nm, sel_r5, en, busy, !cmp);
    end
    wait_empty(nm);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sat !== exp_sat || err !== 1'b0 || int'(iter_cnt) !== exp_iter) begin
      errors++;
      $display("FAIL %s_hold: busy=%b sat=%b err=%b iter=%0d, expected 0 %b 0 %0d",
               nm, busy, sat, err, iter_cnt, exp_sat, exp_iter);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    start = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_state");
    checks++;
    if (busy4 !== 1'b0 || iter_cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state4: busy=%b iter=%0d, expected 0 0", busy4, iter_cnt4);
    end
    @(posedge clk); #1;
    reset = 0;
    start = 0;
    @(negedge clk);
    check_reset_vals("reset_release");
  endtask

  task automatic test_normal();
    op(4, 0, 0, 0, 0, 3, "normal");
  endtask

  task automatic test_clamp();
    op(2, 1, 1, 0, 1, 1, "clamp");
  endtask

  task automatic test_zero();
    op(1, 0, 0, 0, 0, 0, "zero");
  endtask

  task automatic test_timeout();
    exp_t e;
    @(posedge clk); #1;
    start4 = 1;
    e.sat = 0; e.err = 1; e.iter = 15; e.t0 = cyc; e.lat = 19;
    q4.push_back(e);
    @(posedge clk); #1;
    start4 = 0;
    for (int i = 0; i < 60 && q4.size() != 0; i++) @(posedge clk);
    checks++;
    if (q4.size() != 0) begin
      errors++;
      $display("FAIL timeout_wait: %0d completions pending, expected 0", q4.size());
      q4.delete();
    end
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || err4 !== 1'b1 || sat4 !== 1'b0 || iter_cnt4 !== 4'd15) begin
      errors++;
      $display("FAIL timeout_hold: busy=%b err=%b sat=%b iter=%0d, expected 0 1 0 15",
               busy4, err4, sat4, iter_cnt4);
    end
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || en !== 1'b1 || int'(iter_cnt) !== 1) begin
      errors++;
      $display("FAIL abort_run2: busy=%b en=%b iter=%0d, expected 1 1 1", busy, en, iter_cnt);
    end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check_reset_vals("abort_idle");
    repeat (6) @(posedge clk);
    op(3, 0, 0, 0, 0, 2, "after_abort");
  endtask

  task automatic test_busy_start();
    op(4, 0, 0, 1, 0, 3, "busy_start");
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL busy_start_idle: busy=%b pending=%0d, expected 0 0", busy, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_clamp();
    test_zero();
    test_timeout();
    test_abort();
    test_busy_start();
    op(2, 0, 0, 0, 0, 1, "back_to_back");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_clamp_controller.md
MUL_CLAMP_CONTROLLER -- requirements
Module: mul_clamp_controller

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the operand width of the controlled datapath and the width of the iteration counter.
REQ-002 The block SHALL have parameter MAX_ITER, default 2**n - 1, giving the RUN-cycle limit before an error abort.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new multiply-and-clamp operation; sampled only in IDLE.
REQ-006 cmp_res  input  1  datapath status: accumulator greater than limit C.
REQ-007 nor_res  input  1  datapath status: down-counter equals zero.
REQ-008 reset_regs  output  1  active-low accumulator clear to datapath.
REQ-009 sel_r1  output  1  down-counter mux select; 0 = load min(A,B), 1 = load decremented value.
REQ-010 sel_r5  output  1  result mux select; 0 = limit C, 1 = accumulator.
REQ-011 en  output  1  accumulator enable.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse on completion.
REQ-014 sat  output  1  valid with done; 1 = result clamped to C.
REQ-015 err  output  1  valid with done; 1 = MAX_ITER exceeded.
REQ-016 iter_cnt  output  n  number of RUN cycles executed in the current or last operation.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN, FINISH, SAT, ERR and DONE.
REQ-018 IDLE outputs: reset_regs=1, sel_r1=0, sel_r5=1, en=0; start=1 moves to LOAD next cycle and start=0 stays in IDLE.
REQ-019 LOAD lasts exactly 1 cycle with outputs reset_regs=0, sel_r1=0, en=0, and clears iter_cnt to 0; LOAD always moves to RUN.
REQ-020 RUN outputs: reset_regs=1, sel_r1=1, en=1; each RUN cycle with no exit condition increments iter_cnt by 1.
REQ-021 RUN exit priority SHALL be cmp_res=1 -> SAT, else nor_res=1 -> FINISH, else iter_cnt==MAX_ITER -> ERR; en SHALL be 0 combinationally in the exit cycle.
REQ-022 FINISH lasts exactly 1 cycle with sel_r5=1 and en=0 (the result register captures the accumulator); sat=0 and err=0 are latched.
REQ-023 SAT lasts exactly 1 cycle with sel_r5=0 and en=0 (the result register captures C); sat=1 and err=0 are latched.
REQ-024 ERR lasts exactly 1 cycle with en=0 and sel_r5=0; err=1 and sat=0 are latched.
REQ-025 DONE asserts done=1 for exactly 1 cycle and then moves to IDLE.
REQ-026 sat, err and iter_cnt SHALL hold their values until the next LOAD.
REQ-027 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-028 Latency from start to done SHALL be 3 + number of RUN cycles.
REQ-029 iter_cnt SHALL never wrap, because ERR is reached at MAX_ITER.

Reset
REQ-030 reset=1 SHALL force IDLE on the next edge from any state, including mid-RUN.
REQ-031 Reset values SHALL be: reset_regs=1, sel_r1=0, sel_r5=1, en=0, busy=0, done=0, sat=0, err=0, iter_cnt=0.
REQ-032 reset SHALL take priority over start in the same cycle.

Structure
REQ-033 The state encoding typedef and the MAX_ITER default SHALL be in a shared controller package.
REQ-034 The iteration counter (clear, increment, terminal-count flag) SHALL be one sub-module, iter_counter; the FSM and output decode SHALL stay in mul_clamp_controller.

Verification
REQ-035 Normal: start for 1 cycle; nor_res=0 for 3 RUN cycles then 1 -> FINISH; done is high 7 cycles after start, with sat=0, err=0, iter_cnt=3.
REQ-036 Clamp: start; cmp_res=1 in the 2nd RUN cycle with nor_res=1 in the same cycle -> SAT wins; sel_r5=0 in SAT; done follows with sat=1, iter_cnt=1.
REQ-037 Zero operand: start; nor_res=1 in the first RUN cycle -> FINISH; iter_cnt=0, done is high 4 cycles after start.
REQ-038 Timeout: n=4, MAX_ITER=15, nor_res and cmp_res held at 0 -> ERR after 15 increments; done with err=1, iter_cnt=15.
REQ-039 Abort: reset pulsed during the 2nd RUN cycle -> IDLE next edge, all outputs at reset values, no done pulse; a subsequent start completes normally.
REQ-040 Busy start: start re-pulsed during RUN -> ignored; exactly one done per accepted start.
